// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 display path: register map, tx state
// encoding and the segment glyphs used by the display sequencer.
package max7219_pkg;

  localparam logic [7:0] REG_NOOP         = 8'h00;
  localparam logic [7:0] REG_DIGIT0       = 8'h01;
  localparam logic [7:0] REG_DIGIT1       = 8'h02;
  localparam logic [7:0] REG_DIGIT2       = 8'h03;
  localparam logic [7:0] REG_DIGIT3       = 8'h04;
  localparam logic [7:0] REG_DIGIT4       = 8'h05;
  localparam logic [7:0] REG_DIGIT5       = 8'h06;
  localparam logic [7:0] REG_DIGIT6       = 8'h07;
  localparam logic [7:0] REG_DIGIT7       = 8'h08;
  localparam logic [7:0] REG_DECODE_MODE  = 8'h09;
  localparam logic [7:0] REG_INTENSITY    = 8'h0A;
  localparam logic [7:0] REG_SCAN_LIMIT   = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN     = 8'h0C;
  localparam logic [7:0] REG_DISPLAY_TEST = 8'h0F;

  localparam int FRAME_BITS = 16;

  typedef enum logic [2:0] {
    TX_IDLE = 3'd0,
    TX_LOW  = 3'd1,
    TX_HIGH = 3'd2,
    TX_HOLD = 3'd3,
    TX_GAP  = 3'd4
  } tx_state_t;

  // No-decode segment patterns, bit order DP A B C D E F G.
  localparam logic [7:0] GLYPH_0 = 8'h7E;
  localparam logic [7:0] GLYPH_1 = 8'h30;
  localparam logic [7:0] GLYPH_2 = 8'h6D;
  localparam logic [7:0] GLYPH_3 = 8'h79;
  localparam logic [7:0] GLYPH_4 = 8'h33;
  localparam logic [7:0] GLYPH_5 = 8'h5B;
  localparam logic [7:0] GLYPH_6 = 8'h5F;
  localparam logic [7:0] GLYPH_7 = 8'h70;
  localparam logic [7:0] GLYPH_8 = 8'h7F;
  localparam logic [7:0] GLYPH_9 = 8'h7B;

endpackage

// File: rtl/max7219_serial_tx.sv
// MAX7219 serial transmitter: shifts one {addr, data} frame MSB first with a
// divided SCK, framed by CS, and reports busy/done to the sequencer.
module max7219_serial_tx
  import max7219_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr_in,
  input  logic [7:0] din,
  input  logic       start,
  output logic       cs,
  output logic       dout,
  output logic       sck,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  tx_state_t   state, state_nxt;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] shreg;
  logic        div_end;
  logic        accept;
  logic        shift;

  assign div_end = (div_cnt == DIV_LAST);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    shift     = 1'b0;
    unique case (state)
      TX_IDLE: begin
        if (start) begin
          state_nxt = TX_LOW;
          accept    = 1'b1;
        end
      end
      TX_LOW:  if (div_end) state_nxt = TX_HIGH;
      TX_HIGH: begin
        if (div_end) begin
          if (bit_cnt == 4'd15) begin
            state_nxt = TX_HOLD;
          end else begin
            state_nxt = TX_LOW;
            shift     = 1'b1;
          end
        end
      end
      TX_HOLD: if (div_end) state_nxt = TX_GAP;
      TX_GAP:  if (div_end) state_nxt = TX_IDLE;
      default: state_nxt = TX_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so every pin is a flop.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= TX_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      dout    <= 1'b0;
      sck     <= 1'b0;
      cs      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= (state_nxt != state) ? 8'd0 : div_cnt + 8'd1;
      if (accept) begin
        shreg   <= {addr_in, din};
        bit_cnt <= 4'd0;
        dout    <= addr_in[7];
      end else if (shift) begin
        shreg   <= {shreg[14:0], 1'b0};
        bit_cnt <= bit_cnt + 4'd1;
        dout    <= shreg[14];
      end
      sck  <= (state_nxt == TX_HIGH);
      cs   <= !(state_nxt inside {TX_LOW, TX_HIGH, TX_HOLD});
      busy <= (state_nxt != TX_IDLE);
      done <= (state == TX_GAP) && (state_nxt == TX_IDLE);
    end
  end

endmodule

// File: tb/tb_max7219_serial_tx.sv
// Directed bench for max7219_serial_tx: one instance at CLK_DIV=4 and one at
// CLK_DIV=1, with a pin-level monitor that decodes frames from sck/dout.
module tb_max7219_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr_a, din_a, addr_b, din_b;
  logic       start_a, start_b;
  logic       cs_a, dout_a, sck_a, busy_a, done_a;
  logic       cs_b, dout_b, sck_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  max7219_serial_tx #(.CLK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .addr_in(addr_a), .din(din_a), .start(start_a),
    .cs(cs_a), .dout(dout_a), .sck(sck_a), .busy(busy_a), .done(done_a)
  );

  max7219_serial_tx #(.CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .addr_in(addr_b), .din(din_b), .start(start_b),
    .cs(cs_b), .dout(dout_b), .sck(sck_b), .busy(busy_b), .done(done_b)
  );

  logic [1:0] sck_v, cs_v, dout_v, busy_v, done_v;
  assign sck_v  = {sck_b, sck_a};
  assign cs_v   = {cs_b, cs_a};
  assign dout_v = {dout_b, dout_a};
  assign busy_v = {busy_b, busy_a};
  assign done_v = {done_b, done_a};

  // Monitor state, index 0 = dut_a, index 1 = dut_b.
  logic        sck_q [2]        = '{1'b0, 1'b0};
  logic        cs_q  [2]        = '{1'b1, 1'b1};
  logic [15:0] bits  [2]        = '{16'h0, 16'h0};
  int          rises [2]        = '{0, 0};
  int          falls [2]        = '{0, 0};
  int          falls_at_rise [2] = '{0, 0};
  int          cs_hi_run [2]    = '{0, 0};
  int          last_cs_hi [2]   = '{0, 0};
  int          busy_run [2]     = '{0, 0};
  int          hi_run [2]       = '{0, 0};
  int          lo_run [2]       = '{0, 0};
  int          max_hi [2]       = '{0, 0};
  int          max_lo [2]       = '{0, 0};
  int          frame_n [2]      = '{0, 0};
  logic [15:0] frame_log [2][16];
  int          busy_log  [2][16];
  int          rise_log  [2][16];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      sck_q[k] <= sck_v[k];
      cs_q[k]  <= cs_v[k];
      if (sck_v[k] && !sck_q[k]) begin
        bits[k]  <= {bits[k][14:0], dout_v[k]};
        rises[k] <= rises[k] + 1;
      end
      if (!sck_v[k] && sck_q[k]) falls[k] <= falls[k] + 1;
      if (!cs_v[k] && cs_q[k]) begin
        rises[k]      <= 0;
        falls[k]      <= 0;
        last_cs_hi[k] <= cs_hi_run[k];
      end
      if (cs_v[k] && !cs_q[k]) falls_at_rise[k] <= falls[k];
      cs_hi_run[k] <= cs_v[k] ? cs_hi_run[k] + 1 : 0;
      busy_run[k]  <= busy_v[k] ? busy_run[k] + 1 : 0;
      hi_run[k]    <= sck_v[k] ? hi_run[k] + 1 : 0;
      lo_run[k]    <= (!sck_v[k] && !cs_v[k]) ? lo_run[k] + 1 : 0;
      if (sck_v[k] && hi_run[k] + 1 > max_hi[k]) max_hi[k] <= hi_run[k] + 1;
      if (!sck_v[k] && !cs_v[k] && lo_run[k] + 1 > max_lo[k]) max_lo[k] <= lo_run[k] + 1;
      if (done_v[k]) begin
        frame_log[k][frame_n[k] % 16] <= bits[k];
        busy_log[k][frame_n[k] % 16]  <= busy_run[k];
        rise_log[k][frame_n[k] % 16]  <= rises[k];
        frame_n[k] <= frame_n[k] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the first negedge where busy is low; a timeout shows as a failed check.
  task automatic wait_idle(input int k, input string tag);
    int n = 0;
    @(negedge clk);
    while (busy_v[k] && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy_v[k]), 32'd0);
  endtask

  task automatic send_a(input logic [7:0] a, input logic [7:0] d);
    addr_a  = a;
    din_a   = d;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
  endtask

  initial begin
    int n0;
    logic bad;

    rst = 1'b1;
    start_a = 1'b0; addr_a = 8'h00; din_a = 8'h00;
    start_b = 1'b0; addr_b = 8'h00; din_b = 8'h00;
    tick(3);
    check("rst_cs",   32'(cs_a),   32'd1);
    check("rst_sck",  32'(sck_a),  32'd0);
    check("rst_dout", 32'(dout_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_b_cs", 32'(cs_b),   32'd1);
    rst = 1'b0;

    // Idle for 200 cycles with start low.
    bad = 1'b0;
    n0  = frame_n[0];
    for (int i = 0; i < 200; i++) begin
      tick(1);
      bad = bad | !cs_a | sck_a | done_a | busy_a;
    end
    check("idle_quiet", 32'(bad), 32'd0);
    check("idle_no_done", 32'(frame_n[0] - n0), 32'd0);

    // Single frame SHUTDOWN=0x01.
    n0 = frame_n[0];
    send_a(8'h0C, 8'h01);
    wait_idle(0, "f1_idle");
    tick(1);
    check("f1_frame", 32'(frame_log[0][n0 % 16]), 32'h0C01);
    check("f1_busy",  32'(busy_log[0][n0 % 16]), 32'd136);
    check("f1_rises", 32'(rise_log[0][n0 % 16]), 32'd16);
    check("f1_falls_before_cs", 32'(falls_at_rise[0]), 32'd16);
    check("f1_done_cnt", 32'(frame_n[0] - n0), 32'd1);

    // Start held high; data switched on the busy=0 cycle.
    n0 = frame_n[0];
    addr_a = 8'h0A; din_a = 8'h00; start_a = 1'b1;
    wait_idle(0, "f2_idle_a");
    addr_a = 8'h09; din_a = 8'hFF;
    wait_idle(0, "f2_idle_b");
    start_a = 1'b0;
    tick(20);
    check("f2_frame_a", 32'(frame_log[0][n0 % 16]), 32'h0A00);
    check("f2_frame_b", 32'(frame_log[0][(n0 + 1) % 16]), 32'h09FF);
    check("f2_cs_gap_ge5", 32'(last_cs_hi[0] >= 5), 32'd1);
    check("f2_done_cnt", 32'(frame_n[0] - n0), 32'd2);

    // Inputs and start disturbed while busy.
    n0 = frame_n[0];
    send_a(8'h0B, 8'h07);
    tick(10);
    addr_a = 8'hFF; din_a = 8'hFF; start_a = 1'b1;
    tick(3);
    start_a = 1'b0;
    wait_idle(0, "f3_idle");
    tick(20);
    check("f3_frame", 32'(frame_log[0][n0 % 16]), 32'h0B07);
    check("f3_done_cnt", 32'(frame_n[0] - n0), 32'd1);

    // Reset after the 7th sck rise.
    n0 = frame_n[0];
    send_a(8'h01, 8'h80);
    for (int i = 0; i < 400 && rises[0] < 7; i++) tick(1);
    check("f4_reached_7", 32'(rises[0] >= 7), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("f4_rst_cs",   32'(cs_a),   32'd1);
    check("f4_rst_sck",  32'(sck_a),  32'd0);
    check("f4_rst_dout", 32'(dout_a), 32'd0);
    check("f4_rst_busy", 32'(busy_a), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(2);
    send_a(8'h05, 8'h5B);
    wait_idle(0, "f4_idle");
    tick(1);
    check("f4_frame", 32'(frame_log[0][n0 % 16]), 32'h055B);
    check("f4_done_cnt", 32'(frame_n[0] - n0), 32'd1);

    // CLK_DIV=1 instance.
    n0 = frame_n[1];
    addr_b = 8'h08; din_b = 8'h7E; start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    wait_idle(1, "f5_idle");
    tick(1);
    check("f5_frame",  32'(frame_log[1][n0 % 16]), 32'h087E);
    check("f5_busy",   32'(busy_log[1][n0 % 16]), 32'd34);
    check("f5_rises",  32'(rise_log[1][n0 % 16]), 32'd16);
    check("f5_max_hi", 32'(max_hi[1]), 32'd1);
    check("f5_max_lo", 32'(max_lo[1]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
